// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package pwm_pkg;

    // Counting mode of the shared timebase.
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Counter direction encoding.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // All-ones duty value for a counter of width w: the "always high" code.
    function automatic logic [31:0] duty_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaled PWM timebase: prescaler, up/up-down counter, boundary-latched period/prescale/mode.
// Latency: cnt_o is registered; load_o is combinational from the current state.
// Backpressure: none; free-running once out of reset.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic               center_mode_i,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               load_o
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   act_period_q, act_period_d;
    logic [PRESC_W-1:0] act_presc_q, act_presc_d;
    pwm_mode_e          act_center_q, act_center_d;

    logic               tick;
    logic               last;
    logic               load;
    logic [CNT_W-1:0]   cnt_inc;

    // Next-state: prescaler tick, end-of-period detect, counter stepping and boundary latch.
    always_comb begin
        presc_cnt_d  = presc_cnt_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        act_period_d = act_period_q;
        act_presc_d  = act_presc_q;
        act_center_d = act_center_q;
        cnt_inc      = cnt_q + CNT_W'(1);

        tick = (presc_cnt_q == act_presc_q);
        // Center mode flips direction when stepping onto the peak, so the peak
        // itself is already "down" and a period of 1 still ends on cnt==1.
        if (act_center_q == PWM_CENTER) begin
            last = (act_period_q == '0) || ((dir_q == DIR_DOWN) && (cnt_q == CNT_W'(1)));
        end else begin
            last = (cnt_q == act_period_q);
        end
        load = tick && last;

        presc_cnt_d = tick ? '0 : (presc_cnt_q + PRESC_W'(1));

        if (load) begin
            cnt_d        = '0;
            dir_d        = DIR_UP;
            act_period_d = period_i;
            act_presc_d  = prescale_i;
            act_center_d = pwm_mode_e'(center_mode_i);
        end else if (tick) begin
            if (act_center_q == PWM_EDGE) begin
                cnt_d = cnt_inc;
            end else if (dir_q == DIR_UP) begin
                cnt_d = cnt_inc;
                if (cnt_inc == act_period_q) begin
                    dir_d = DIR_DOWN;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Timebase state; first period after reset runs the full all-ones range.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_cnt_q  <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            act_period_q <= '1;
            act_presc_q  <= '0;
            act_center_q <= PWM_EDGE;
        end else begin
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            act_period_q <= act_period_d;
            act_presc_q  <= act_presc_d;
            act_center_q <= act_center_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign load_o = load;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shadowed per-channel duty, shared timebase, registered pin outputs.
// Latency: out lags the counter by one clk; enable changes show after one clk.
// Backpressure: none; duty writes are accepted every cycle, out-of-range channels dropped.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter  int NUM_CH  = 16,
    parameter  int CNT_W   = 8,
    parameter  int PRESC_W = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic               duty_wr_en,
    input  logic [CH_W-1:0]    duty_wr_ch,
    input  logic [CNT_W-1:0]   duty_wr_data,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    localparam logic [CNT_W-1:0] DUTY_FULL = CNT_W'(duty_max(CNT_W));

    logic [CNT_W-1:0]  cnt;
    logic              load;

    logic [CNT_W-1:0]  shadow_q   [NUM_CH];
    logic [CNT_W-1:0]  shadow_d   [NUM_CH];
    logic [CNT_W-1:0]  act_duty_q [NUM_CH];
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              period_start_q;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .period_i      (period),
        .prescale_i    (prescale),
        .center_mode_i (center_mode),
        .cnt_o         (cnt),
        .load_o        (load)
    );

    // Write decode; a channel index with no matching channel updates nothing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (duty_wr_en && (duty_wr_ch == CH_W'(i))) begin
                shadow_d[i] = duty_wr_data;
            end
        end
    end

    // Shadow takes writes any time; active duty only moves at the period boundary,
    // taking a same-cycle write directly so it is not lost for a whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i]   <= '0;
                act_duty_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (load) begin
                    act_duty_q[i] <= shadow_d[i];
                end
            end
        end
    end

    // Compare and pin gating: all-ones duty is solid high, disabled PWM is static high.
    always_comb begin
        pwm   = '0;
        out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm[i]   = (act_duty_q[i] == DUTY_FULL) || (cnt < act_duty_q[i]);
            out_d[i] = en_out[i] & (en_pwm[i] ? pwm[i] : 1'b1);
        end
    end

    // Output registers; period_start marks the first cycle with cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            period_start_q <= load;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule
